id_exe_pipe_reg: RTL and testbench
==================================

// Module: id_exe_pipe_reg
// PURPOSE
//  ID->EXE pipeline register of the 5-stage ARM-subset core. Captures decoded
//  control (wb_en, mem_read_en, mem_write_en, B, S, exe_cmd) from the control unit,
//  operands from the register file and immediate fields. Presents them to the EXE stage one cycle later.
//  Supports hazard freeze (hold), branch flush (bubble insert) and a saturating bubble counter.
// PARAMETERS
//  WORD_W      32  datapath width (PC, operand values)
//  REG_ADDR_W  4   register-file address width
//  CNT_W       16  width of bubble_count perf counter
// PORTS
//  clk              in   1           rising-edge clock
//  rst              in   1           synchronous, active-high reset
//  freeze           in   1           hazard stall: hold all contents
//  flush            in   1           branch taken in EXE: load bubble
//  valid_in         in   1           ID stage holds a real instruction
//  wb_en_in         in   1           control: register write-back
//  mem_read_en_in   in   1           control: load
//  mem_write_en_in  in   1           control: store
//  b_in             in   1           control: branch
//  s_in             in   1           control: update status flags
//  exe_cmd_in       in   4           ALU command
//  pc_in            in   WORD_W      PC+4 of instruction
//  val_rn_in        in   WORD_W      Rn value
//  val_rm_in        in   WORD_W      Rm value
//  imm_in           in   1           I bit
//  shift_operand_in in   12          shifter operand field
//  simm24_in        in   24          branch offset
//  dest_in          in   REG_ADDR_W  Rd
//  src1_in, src2_in in   REG_ADDR_W  source regs (forwarding)
//  sr_in            in   4           status flags {N,Z,C,V}
//  *_out            out  (same)      registered copy of every *_in above, plus valid_out
//  bubble_count     out  CNT_W       bubbles inserted since reset
// BEHAVIOUR
//  - All outputs are registered. Latency is exactly 1 cycle from *_in to *_out. No combinational path.
//  - Per-edge priority: rst > flush > freeze > load.
//  - rst=1: every *_out and bubble_count go to 0, including valid_out and exe_cmd_out=4'b0000.
//  - flush=1: valid_out, wb_en_out, mem_read_en_out, mem_write_en_out, b_out and s_out go to 0.
//    exe_cmd_out goes to 0. Data/address fields also go to 0. This is deterministic, not "don't care".
//  - flush and freeze both 1: flush wins. A taken branch squashes the stalled instruction.
//  - freeze=1 (flush=0): all outputs hold their previous value, bubble_count included.
//  - Otherwise load: every *_out <= *_in.
//  - valid_in=0 on load: store the fields as given. valid_out=0.
//    Control signals are NOT masked. The control unit already drives 0 for bubbles.
//  - bubble_count increments by 1 on every edge where, with rst=0:
//    (a) flush=1, or
//    (b) a load occurs with valid_in=0.
//    It saturates at 2^CNT_W-1 and never wraps.
//  - mem_read_en_out and mem_write_en_out are never both 1. This holds by construction of upstream.
//    The bench asserts it.
//  - Reset mid-stall: rst during freeze clears everything. Freeze has no effect on rst.
//  - No internal FSM beyond the register/valid state. The block is a pure, strictly synchronous stage.
// TESTING
//  1. rst=1 for 2 cycles with random inputs -> all outputs 0 and bubble_count=0.
//  2. Load: ADD (exe_cmd_in=4'b0010, wb_en_in=1, val_rn_in=32'h5, dest_in=3, valid_in=1)
//     -> next cycle exe_cmd_out=2, wb_en_out=1, val_rn_out=5, dest_out=3, valid_out=1.
//  3. freeze=1 for 3 cycles while inputs change to SUB -> outputs stay ADD. Release -> SUB appears 1 cycle later.
//  4. flush=1 and freeze=1 together, with an LDR loaded (mem_read_en_out=1)
//     -> next cycle all control outputs 0, valid_out=0, bubble_count +1.
//  5. CNT_W=4: drive flush=1 for 20 cycles -> bubble_count reaches 15 and stays at 15.
//  6. Assert rst during freeze with STR held -> next cycle mem_write_en_out=0 and all outputs 0.
//     Then load MOV -> MOV appears 1 cycle later.

Source files
------------

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE stage register: decoded control, operands and immediates for the EXE stage.
// Latency 1 cycle; freeze holds contents, flush loads a zeroed bubble and counts it.
// No backpressure out: freeze is the only stall and it simply holds contents in place.
module id_exe_pipe_reg #(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic                  wb_en_in,
    input  logic                  mem_read_en_in,
    input  logic                  mem_write_en_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic [3:0]            exe_cmd_in,
    input  logic [WORD_W-1:0]     pc_in,
    input  logic [WORD_W-1:0]     val_rn_in,
    input  logic [WORD_W-1:0]     val_rm_in,
    input  logic                  imm_in,
    input  logic [11:0]           shift_operand_in,
    input  logic [23:0]           simm24_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic [3:0]            sr_in,
    output logic                  valid_out,
    output logic                  wb_en_out,
    output logic                  mem_read_en_out,
    output logic                  mem_write_en_out,
    output logic                  b_out,
    output logic                  s_out,
    output logic [3:0]            exe_cmd_out,
    output logic [WORD_W-1:0]     pc_out,
    output logic [WORD_W-1:0]     val_rn_out,
    output logic [WORD_W-1:0]     val_rm_out,
    output logic                  imm_out,
    output logic [11:0]           shift_operand_out,
    output logic [23:0]           simm24_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [REG_ADDR_W-1:0] src1_out,
    output logic [REG_ADDR_W-1:0] src2_out,
    output logic [3:0]            sr_out,
    output logic [CNT_W-1:0]      bubble_count
);

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_read_en;
        logic                  mem_write_en;
        logic                  b;
        logic                  s;
        logic [3:0]            exe_cmd;
        logic [WORD_W-1:0]     pc;
        logic [WORD_W-1:0]     val_rn;
        logic [WORD_W-1:0]     val_rm;
        logic                  imm;
        logic [11:0]           shift_operand;
        logic [23:0]           simm24;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic [3:0]            sr;
    } stage_t;

    stage_t           stage_d;
    stage_t           stage_q;
    logic [CNT_W-1:0] count_inc;

    assign stage_d = {valid_in, wb_en_in, mem_read_en_in, mem_write_en_in, b_in, s_in,
                      exe_cmd_in, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                      simm24_in, dest_in, src1_in, src2_in, sr_in};

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign count_inc = (bubble_count == '1) ? bubble_count : bubble_count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q      <= '0;
            bubble_count <= '0;
        end else if (flush) begin
            stage_q      <= '0;
            bubble_count <= count_inc;
        end else if (!freeze) begin
            stage_q <= stage_d;
            if (!valid_in)
                bubble_count <= count_inc;
        end
    end

    assign valid_out         = stage_q.valid;
    assign wb_en_out         = stage_q.wb_en;
    assign mem_read_en_out   = stage_q.mem_read_en;
    assign mem_write_en_out  = stage_q.mem_write_en;
    assign b_out             = stage_q.b;
    assign s_out             = stage_q.s;
    assign exe_cmd_out       = stage_q.exe_cmd;
    assign pc_out            = stage_q.pc;
    assign val_rn_out        = stage_q.val_rn;
    assign val_rm_out        = stage_q.val_rm;
    assign imm_out           = stage_q.imm;
    assign shift_operand_out = stage_q.shift_operand;
    assign simm24_out        = stage_q.simm24;
    assign dest_out          = stage_q.dest;
    assign src1_out          = stage_q.src1;
    assign src2_out          = stage_q.src2;
    assign sr_out            = stage_q.sr;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Bench for id_exe_pipe_reg: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the stage.
module tb_id_exe_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic        wb_en;
        logic        mem_read_en;
        logic        mem_write_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] simm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  sr;
    } fields_t;

    logic    clk = 1'b0;
    logic    rst, freeze, flush;
    fields_t in_f;
    fields_t out_f;
    fields_t exp_f;
    int      bubbles;
    int      errors = 0;
    int      checks = 0;

    logic        valid_out, wb_en_out, mem_read_en_out, mem_write_en_out, b_out, s_out;
    logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, sr_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic        imm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] simm24_out;
    logic [3:0]  bubble_count;

    always #5 clk = ~clk;

    id_exe_pipe_reg #(.WORD_W(32), .REG_ADDR_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(in_f.valid), .wb_en_in(in_f.wb_en), .mem_read_en_in(in_f.mem_read_en),
        .mem_write_en_in(in_f.mem_write_en), .b_in(in_f.b), .s_in(in_f.s),
        .exe_cmd_in(in_f.exe_cmd), .pc_in(in_f.pc), .val_rn_in(in_f.val_rn),
        .val_rm_in(in_f.val_rm), .imm_in(in_f.imm), .shift_operand_in(in_f.shift_operand),
        .simm24_in(in_f.simm24), .dest_in(in_f.dest), .src1_in(in_f.src1),
        .src2_in(in_f.src2), .sr_in(in_f.sr),
        .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_read_en_out(mem_read_en_out),
        .mem_write_en_out(mem_write_en_out), .b_out(b_out), .s_out(s_out),
        .exe_cmd_out(exe_cmd_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
        .val_rm_out(val_rm_out), .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .simm24_out(simm24_out), .dest_out(dest_out), .src1_out(src1_out),
        .src2_out(src2_out), .sr_out(sr_out), .bubble_count(bubble_count)
    );

    assign out_f = {valid_out, wb_en_out, mem_read_en_out, mem_write_en_out, b_out, s_out,
                    exe_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                    simm24_out, dest_out, src1_out, src2_out, sr_out};

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: the model reacts to what the stage saw at the edge, then outputs are compared.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            exp_f   = '0;
            bubbles = 0;
        end else if (flush) begin
            exp_f   = '0;
            bubbles = bubbles + 1;
        end else if (!freeze) begin
            exp_f = in_f;
            if (!in_f.valid) bubbles = bubbles + 1;
        end
        #1;
        chk("fields", 192'(out_f), 192'(exp_f));
        chk("bubble_count", 192'(bubble_count), 192'((bubbles > 15) ? 15 : bubbles));
        chk("rd_wr_excl", 192'(mem_read_en_out & mem_write_en_out), 192'(0));
    endtask

    task automatic rand_inputs();
        in_f = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (in_f.mem_read_en) in_f.mem_write_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        exp_f = '0; bubbles = 0;
        rand_inputs();
        #2;

        // 1. reset with random inputs
        step();
        rand_inputs(); flush = 1'b1; freeze = 1'b1;
        step();
        chk("rst_all_zero", 192'(out_f), 192'(0));
        chk("rst_count", 192'(bubble_count), 192'(0));

        // 2. ADD load
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        in_f = '0;
        in_f.valid = 1'b1; in_f.wb_en = 1'b1; in_f.exe_cmd = 4'b0010;
        in_f.val_rn = 32'h5; in_f.dest = 4'd3;
        step();
        chk("add_cmd", 192'(exe_cmd_out), 192'(2));
        chk("add_wb", 192'(wb_en_out), 192'(1));
        chk("add_rn", 192'(val_rn_out), 192'(5));
        chk("add_dest", 192'(dest_out), 192'(3));
        chk("add_valid", 192'(valid_out), 192'(1));

        // 3. freeze 3 cycles while SUB waits upstream
        freeze = 1'b1;
        in_f.exe_cmd = 4'b0100; in_f.val_rn = 32'h9; in_f.dest = 4'd4; in_f.s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_hold_cmd", 192'(exe_cmd_out), 192'(2));
        end
        freeze = 1'b0;
        step();
        chk("sub_cmd", 192'(exe_cmd_out), 192'(4));
        chk("sub_dest", 192'(dest_out), 192'(4));

        // 4. LDR then flush+freeze together
        in_f = '0;
        in_f.valid = 1'b1; in_f.wb_en = 1'b1; in_f.mem_read_en = 1'b1; in_f.exe_cmd = 4'b0010;
        in_f.pc = 32'h40; in_f.dest = 4'd7;
        step();
        chk("ldr_rd", 192'(mem_read_en_out), 192'(1));
        flush = 1'b1; freeze = 1'b1;
        step();
        chk("flush_ctl", 192'({valid_out, wb_en_out, mem_read_en_out, mem_write_en_out,
                               b_out, s_out, exe_cmd_out}), 192'(0));
        chk("flush_count", 192'(bubble_count), 192'(1));

        // 5. 20 flushes saturate the 4-bit counter
        freeze = 1'b0;
        for (int i = 0; i < 19; i++) step();
        chk("sat_15", 192'(bubble_count), 192'(15));
        step();
        chk("sat_hold", 192'(bubble_count), 192'(15));

        // 6. reset during a frozen STR, then MOV
        flush = 1'b0;
        in_f = '0;
        in_f.valid = 1'b1; in_f.mem_write_en = 1'b1; in_f.exe_cmd = 4'b0010; in_f.val_rm = 32'hABCD;
        step();
        chk("str_wr", 192'(mem_write_en_out), 192'(1));
        freeze = 1'b1;
        rand_inputs();
        step();
        chk("str_held", 192'(mem_write_en_out), 192'(1));
        rst = 1'b1;
        step();
        chk("rst_frz_wr", 192'(mem_write_en_out), 192'(0));
        chk("rst_frz_all", 192'(out_f), 192'(0));
        rst = 1'b0; freeze = 1'b0;
        in_f = '0;
        in_f.valid = 1'b1; in_f.wb_en = 1'b1; in_f.exe_cmd = 4'b0001;
        in_f.val_rm = 32'h1234; in_f.dest = 4'd2;
        step();
        chk("mov_cmd", 192'(exe_cmd_out), 192'(1));
        chk("mov_rm", 192'(val_rm_out), 192'(32'h1234));

        // random traffic with occasional resets to keep the counter off saturation
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst    = ($urandom_range(0, 15) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
